// File: rtl/riscv_pc_pkg.sv
// Shared types and constants for the next-PC generator.
// Feature macro used by the design: PC_NEXT_GEN_MISALIGN_TRAP_EN.
package riscv_pc_pkg;

    localparam int unsigned PC_W = 32;
    localparam logic [PC_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StHold = 2'd2,
        StPend = 2'd3
    } pc_state_e;

endpackage

// File: rtl/pc_next_gen_if.sv
// Bundle of PC-register link, pipeline control, fetch request and status signals.
// master: the next-PC generator; slave: the pipeline/memory side driving it.
interface pc_next_gen_if;
    import riscv_pc_pkg::*;

    logic [PC_W-1:0] pc_actual;
    logic [PC_W-1:0] pc_next;
    logic            stall;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_target;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic            kill_resp;
    logic            misalign_trap;

    modport master (
        input  pc_actual,
        input  stall,
        input  redirect_valid,
        input  redirect_target,
        input  imem_req_ready,
        output pc_next,
        output imem_req_valid,
        output kill_resp,
        output misalign_trap
    );

    modport slave (
        output pc_actual,
        output stall,
        output redirect_valid,
        output redirect_target,
        output imem_req_ready,
        input  pc_next,
        input  imem_req_valid,
        input  kill_resp,
        input  misalign_trap
    );

endinterface

// File: rtl/pc_redirect_buffer.sv
// Holds a redirect that arrived while a fetch was still outstanding.
// The first load wins; later loads are locked out until clear or reset.
// With PC_NEXT_GEN_MISALIGN_TRAP_EN defined, a trap flag is stored with the target.
module pc_redirect_buffer
    import riscv_pc_pkg::*;
(
    input  logic            CLK,
    input  logic            reset,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [PC_W-1:0] target_i,
`ifdef PC_NEXT_GEN_MISALIGN_TRAP_EN
    input  logic            trap_i,
    output logic            trap_o,
`endif
    output logic [PC_W-1:0] target_o
);

    logic            valid_q, valid_d;
    logic [PC_W-1:0] target_q, target_d;
`ifdef PC_NEXT_GEN_MISALIGN_TRAP_EN
    logic            trap_q, trap_d;
`endif

    // Next-state: clear has priority, load only accepted while empty.
    always_comb begin
        valid_d  = valid_q;
        target_d = target_q;
`ifdef PC_NEXT_GEN_MISALIGN_TRAP_EN
        trap_d   = trap_q;
`endif
        if (clear_i) begin
            valid_d  = 1'b0;
            target_d = '0;
`ifdef PC_NEXT_GEN_MISALIGN_TRAP_EN
            trap_d   = 1'b0;
`endif
        end else if (load_i && !valid_q) begin
            valid_d  = 1'b1;
            target_d = target_i;
`ifdef PC_NEXT_GEN_MISALIGN_TRAP_EN
            trap_d   = trap_i;
`endif
        end
    end

    // Capture register, synchronously cleared by reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            valid_q  <= 1'b0;
            target_q <= '0;
`ifdef PC_NEXT_GEN_MISALIGN_TRAP_EN
            trap_q   <= 1'b0;
`endif
        end else begin
            valid_q  <= valid_d;
            target_q <= target_d;
`ifdef PC_NEXT_GEN_MISALIGN_TRAP_EN
            trap_q   <= trap_d;
`endif
        end
    end

    assign target_o = target_q;
`ifdef PC_NEXT_GEN_MISALIGN_TRAP_EN
    assign trap_o   = trap_q;
`endif

endmodule

// File: rtl/pc_next_gen.sv
// Next-PC generator: boot, sequential fetch, redirects and stalls, while never moving
// the fetch address under an outstanding request. Flags wrong-path responses.
// PC_NEXT_GEN_MISALIGN_TRAP_EN: misaligned redirects go to TRAP_VECTOR and pulse
// misalign_trap; otherwise targets are force-aligned and misalign_trap stays 0.
module pc_next_gen
    import riscv_pc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [PC_W-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic          CLK,
    input  logic          reset,
    pc_next_gen_if.master bus_io
);

    pc_state_e       state_q, state_d;
    logic            acc;
    logic            buf_load, buf_clear;
    logic [PC_W-1:0] aligned_target, resolved_target;
    logic            resolved_trap;
    logic [PC_W-1:0] pend_target;
    logic            pend_trap;

    assign aligned_target = bus_io.redirect_target & ~(PC_STEP - 32'd1);
`ifdef PC_NEXT_GEN_MISALIGN_TRAP_EN
    assign resolved_trap  = (bus_io.redirect_target[1:0] != 2'b00);
`else
    assign resolved_trap  = 1'b0;
`endif
    assign resolved_target = resolved_trap ? TRAP_VECTOR : aligned_target;

    assign acc = bus_io.imem_req_valid && bus_io.imem_req_ready;

    pc_redirect_buffer u_redirect_buffer (
        .CLK      (CLK),
        .reset    (reset),
        .load_i   (buf_load),
        .clear_i  (buf_clear),
        .target_i (resolved_target),
`ifdef PC_NEXT_GEN_MISALIGN_TRAP_EN
        .trap_i   (resolved_trap),
        .trap_o   (pend_trap),
`endif
        .target_o (pend_target)
    );

`ifndef PC_NEXT_GEN_MISALIGN_TRAP_EN
    assign pend_trap = 1'b0;
`endif

    // Next state, next-PC mux and Mealy outputs.
    always_comb begin
        state_d               = state_q;
        bus_io.pc_next        = bus_io.pc_actual;
        bus_io.imem_req_valid = 1'b0;
        bus_io.misalign_trap  = 1'b0;
        buf_load              = 1'b0;
        buf_clear             = 1'b0;

        unique case (state_q)
            StBoot: begin
                bus_io.pc_next = RESET_VECTOR;
                state_d        = StRun;
            end
            StRun, StHold: begin
                // Once raised, a request is held until accepted regardless of stall.
                bus_io.imem_req_valid = (state_q == StHold) || !bus_io.stall;
                if (bus_io.redirect_valid) begin
                    if (!bus_io.imem_req_valid || acc) begin
                        bus_io.pc_next       = resolved_target;
                        bus_io.misalign_trap = resolved_trap;
                        state_d              = StRun;
                    end else begin
                        buf_load = 1'b1;
                        state_d  = StPend;
                    end
                end else if (acc) begin
                    bus_io.pc_next = bus_io.pc_actual + PC_STEP;
                    state_d        = StRun;
                end else if (bus_io.imem_req_valid) begin
                    state_d = StHold;
                end
            end
            StPend: begin
                // Later redirects are wrong-path; the captured one wins.
                bus_io.imem_req_valid = 1'b1;
                if (acc) begin
                    bus_io.pc_next       = pend_target;
                    bus_io.misalign_trap = pend_trap;
                    buf_clear            = 1'b1;
                    state_d              = StRun;
                end
            end
            default: state_d = StBoot;
        endcase

        if (reset) begin
            state_d               = StBoot;
            bus_io.pc_next        = RESET_VECTOR;
            bus_io.imem_req_valid = 1'b0;
            bus_io.misalign_trap  = 1'b0;
            buf_load              = 1'b0;
            buf_clear             = 1'b0;
        end
    end

    // kill_resp derives from the final request valid so reset masks it too.
    assign bus_io.kill_resp = bus_io.imem_req_valid && bus_io.imem_req_ready &&
                              ((state_q == StPend) || bus_io.redirect_valid);

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_pc_next_gen.sv
// Directed bench for pc_next_gen with a scoreboard of expected per-cycle outputs.
// Honours PC_NEXT_GEN_MISALIGN_TRAP_EN for the misaligned-redirect expectations.
module tb_pc_next_gen;

`ifdef PC_NEXT_GEN_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    typedef struct {
        string       tag;
        bit          chk_pc;
        logic [31:0] pc;
        logic [31:0] nxt;
        logic        v;
        logic        k;
        logic        t;
    } exp_t;

    logic CLK;
    logic reset;
    exp_t sb[$];
    int   vectors;
    int   miscompares;

    pc_next_gen_if bus ();

    pc_next_gen dut (
        .CLK    (CLK),
        .reset  (reset),
        .bus_io (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Models the PC_next register that the generator feeds.
    always @(posedge CLK) bus.pc_actual <= bus.pc_next;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, compare mid-cycle.
    task automatic step(input string tag, input logic rst, input logic stl, input logic rv,
                        input logic [31:0] rt, input logic rdy, input bit chk_pc,
                        input logic [31:0] exp_pc, input logic [31:0] exp_nxt,
                        input logic exp_v, input logic exp_k, input logic exp_t);
        exp_t e;
        reset               = rst;
        bus.stall           = stl;
        bus.redirect_valid  = rv;
        bus.redirect_target = rt;
        bus.imem_req_ready  = rdy;
        sb.push_back('{tag, chk_pc, exp_pc, exp_nxt, exp_v, exp_k, exp_t});
        @(negedge CLK);
        e = sb.pop_front();
        if (e.chk_pc) chk32({e.tag, ".pc_actual"}, bus.pc_actual, e.pc);
        chk32({e.tag, ".pc_next"}, bus.pc_next, e.nxt);
        chk1({e.tag, ".req_valid"}, bus.imem_req_valid, e.v);
        chk1({e.tag, ".kill_resp"}, bus.kill_resp, e.k);
        chk1({e.tag, ".misalign_trap"}, bus.misalign_trap, e.t);
        @(posedge CLK);
        #1;
    endtask

    localparam logic [31:0] MisA = TrapEn ? 32'h100 : 32'h200;
    localparam logic [31:0] MisB = TrapEn ? 32'h100 : 32'h600;

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = '0;
        bus.imem_req_ready = 1'b1;
        @(posedge CLK);
        #1;
        //   tag          rst stl rv target        rdy chk pc           next          v  k  t
        step("reset",     1, 0, 0, 32'h0,        1, 0, 32'h0,        32'h0,        0, 0, 0);
        step("boot",      0, 0, 1, 32'h900,      1, 1, 32'h0,        32'h0,        0, 0, 0);
        step("seq0",      0, 0, 0, 32'h0,        1, 1, 32'h0,        32'h4,        1, 0, 0);
        step("seq4",      0, 0, 0, 32'h0,        1, 1, 32'h4,        32'h8,        1, 0, 0);
        step("seq8",      0, 0, 0, 32'h0,        1, 1, 32'h8,        32'hC,        1, 0, 0);
        step("seq12",     0, 0, 0, 32'h0,        1, 1, 32'hC,        32'h10,       1, 0, 0);
        step("bp1",       0, 0, 0, 32'h0,        0, 1, 32'h10,       32'h10,       1, 0, 0);
        step("bp2_stall", 0, 1, 0, 32'h0,        0, 1, 32'h10,       32'h10,       1, 0, 0);
        step("bp3",       0, 0, 0, 32'h0,        0, 1, 32'h10,       32'h10,       1, 0, 0);
        step("bp_acc",    0, 0, 0, 32'h0,        1, 1, 32'h10,       32'h14,       1, 0, 0);
        step("redir",     0, 0, 1, 32'h200,      1, 1, 32'h14,       32'h200,      1, 1, 0);
        step("redir_pc",  0, 0, 0, 32'h0,        1, 1, 32'h200,      32'h204,      1, 0, 0);
        step("pend_in",   0, 0, 1, 32'h300,      0, 1, 32'h204,      32'h204,      1, 0, 0);
        step("pend_2nd",  0, 0, 1, 32'h400,      0, 1, 32'h204,      32'h204,      1, 0, 0);
        step("pend_acc",  0, 0, 1, 32'h400,      1, 1, 32'h204,      32'h300,      1, 1, 0);
        step("pend_pc",   0, 0, 0, 32'h0,        1, 1, 32'h300,      32'h304,      1, 0, 0);
        step("mis_dir",   0, 0, 1, 32'h202,      1, 1, 32'h304,      MisA,         1, 1, TrapEn);
        step("mis_after", 0, 0, 0, 32'h0,        1, 1, MisA,         MisA + 32'd4, 1, 0, 0);
        step("stl_redir", 0, 1, 1, 32'h500,      1, 1, MisA + 32'd4, 32'h500,      0, 0, 0);
        step("stl_hold",  0, 1, 0, 32'h0,        1, 1, 32'h500,      32'h500,      0, 0, 0);
        step("mis_pend",  0, 0, 1, 32'h603,      0, 1, 32'h500,      32'h500,      1, 0, 0);
        step("mis_pacc",  0, 0, 0, 32'h0,        1, 1, 32'h500,      MisB,         1, 1, TrapEn);
        step("pend2_in",  0, 0, 1, 32'h700,      0, 1, MisB,         MisB,         1, 0, 0);
        step("pend_rst",  1, 0, 0, 32'h0,        1, 1, MisB,         32'h0,        0, 0, 0);
        step("reboot",    0, 0, 0, 32'h0,        1, 1, 32'h0,        32'h0,        0, 0, 0);
        step("rerun0",    0, 0, 0, 32'h0,        1, 1, 32'h0,        32'h4,        1, 0, 0);
        step("to_top",    0, 0, 1, 32'hFFFF_FFFC, 1, 1, 32'h4,       32'hFFFF_FFFC, 1, 1, 0);
        step("wrap",      0, 0, 0, 32'h0,        1, 1, 32'hFFFF_FFFC, 32'h0,       1, 0, 0);
        step("post_wrap", 0, 0, 0, 32'h0,        1, 1, 32'h0,        32'h4,        1, 0, 0);
        step("hold_in",   0, 0, 0, 32'h0,        0, 1, 32'h4,        32'h4,        1, 0, 0);
        step("hold_redir",0, 1, 1, 32'h800,      0, 1, 32'h4,        32'h4,        1, 0, 0);
        step("hold_pacc", 0, 0, 0, 32'h0,        1, 1, 32'h4,        32'h800,      1, 1, 0);
        step("hold_pc",   0, 0, 0, 32'h0,        1, 1, 32'h800,      32'h804,      1, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_next_gen.md
# pc_next_gen

Next-PC generator paired with the `PC_next` register: it consumes `pc_actual`, issues instruction-fetch requests for it, and drives `pc_next` back into the register every cycle. It sequences boot, sequential fetch (+4), execute-stage redirects (branch/JAL/JALR), and stalls. It never moves the fetch address while a request is outstanding, and it flags wrong-path fetch responses for discard.

## Interface
Parameters:
- `RESET_VECTOR`, default 32'h0000_0000: PC loaded out of reset.
- `TRAP_VECTOR`, default 32'h0000_0100: target used for misaligned redirects when the trap feature is compiled in.

Ports:
- Clocking and reset:
  - `CLK` input 1: single clock; everything updates on its rising edge.
  - `reset` input 1: synchronous, active-high.
- PC register link:
  - `pc_actual` input 32: current PC, from `PC_next`.
  - `pc_next` output 32: value `PC_next` loads on every edge.
- Pipeline control:
  - `stall` input 1: decode/hazard stall. Blocks issuing a new fetch.
  - `redirect_valid` input 1: execute-stage redirect request.
  - `redirect_target` input 32: redirect address.
- Instruction-memory request:
  - `imem_req_valid` output 1: fetch request for address `pc_actual`.
  - `imem_req_ready` input 1: memory accepts the request.
- Status:
  - `kill_resp` output 1: the request accepted this cycle is wrong-path, and its response must be dropped.
  - `misalign_trap` output 1: a misaligned redirect was converted to a trap.

## Operation
- The FSM has four states: BOOT, RUN, HOLD, PEND. `pend_target` is 32 bits and `pend_trap` is 1 bit.
- Handshake: the request is accepted ("acc") when `imem_req_valid && imem_req_ready`.
- Protocol rule: once `imem_req_valid` rises, it stays high and `pc_actual` stays constant until acceptance. Reset is the only exception.
- Redirect target resolution:
  - "Resolved target" means `redirect_target`, processed per Configuration.
  - Arithmetic is modulo 2^32. `pc_actual + 4` wraps from 32'hFFFF_FFFC to 0.
- Reset cycle:
  - `pc_next` = `RESET_VECTOR`.
  - `imem_req_valid`, `kill_resp`, `misalign_trap` = 0.
  - Pending state is cleared. Next state is BOOT.
- BOOT (one cycle):
  - `imem_req_valid` = 0, `pc_next` = `RESET_VECTOR`.
  - Redirects are ignored. Next state is RUN.
- RUN:
  - `imem_req_valid` = `!stall`.
  - If redirect and (no request, or acc): `pc_next` = resolved target; stay in RUN.
  - If redirect and request not accepted: `pc_next` = `pc_actual`; capture the target into `pend_*`; go to PEND.
  - If no redirect and acc: `pc_next` = `pc_actual + 4`.
  - If no redirect and the request is not accepted: `pc_next` = `pc_actual`; go to HOLD.
  - If no request: `pc_next` = `pc_actual`.
- HOLD:
  - `imem_req_valid` = 1, regardless of `stall`.
  - The redirect and acc rules are the same as in RUN. Acc returns to RUN; redirect without acc goes to PEND.
- PEND:
  - `imem_req_valid` = 1 and `pc_next` = `pc_actual` until acc.
  - On acc: `pc_next` = `pend_target`; go to RUN.
  - Further redirects in PEND are ignored, because they come from wrong-path instructions; the first captured redirect wins.
- `kill_resp` = acc && (state == PEND || `redirect_valid`).
- Simultaneous `stall` and `redirect_valid` in RUN: the redirect applies and no request issues.

## Timing
- Outputs are Mealy-combinational from the registered state plus inputs. `pc_next` settles within the cycle.
- Redirect latency:
  - Applied directly: `pc_actual` equals the target one edge later.
  - Deferred via PEND: the target is applied at the edge ending the acc cycle.
- Sequential fetch rate: one request per cycle while `imem_req_ready` = 1 and `stall` = 0.
- Reset mid-operation (including in PEND with a pending redirect):
  - `imem_req_valid` drops in the reset cycle.
  - The pending redirect is discarded.
  - BOOT follows, then the first request issues to `RESET_VECTOR` one cycle after BOOT.

## Configuration
`PC_NEXT_GEN_MISALIGN_TRAP_EN` controls misaligned redirects:
- Defined: a redirect with `redirect_target[1:0] != 0` resolves to `TRAP_VECTOR`. `misalign_trap` pulses for exactly one cycle when that target is driven onto `pc_next`, which is the PEND acc cycle if deferred (from `pend_trap`).
- Undefined: the resolved target is `{redirect_target[31:2], 2'b00}`, `misalign_trap` is tied to 0, and `pend_trap` is not built.

## Structure
- Package `riscv_pc_pkg`:
  - FSM state encoding (BOOT/RUN/HOLD/PEND).
  - `PC_STEP` = 4.
  - `PC_W` = 32.
- Sub-module `pc_redirect_buffer`:
  - Holds the `pend_target` / `pend_trap` capture register.
  - Has load, clear, and "first-wins" lockout.
  - The FSM and next-PC mux stay in `pc_next_gen`.

## Test plan
- Reset release with `imem_req_ready` = 1:
  - Cycle 0 (BOOT): `imem_req_valid` = 0, `pc_next` = 0.
  - Afterwards, `pc_actual` runs 0, 4, 8, 12, one per cycle, with `kill_resp` = 0.
- Backpressure: `imem_req_ready` = 0 for 3 cycles at PC 32'h10.
  - `pc_next` = 32'h10 and `imem_req_valid` = 1 throughout, even with `stall` = 1 asserted in cycle 2.
  - On ready, `pc_next` = 32'h14.
- Direct redirect: in RUN with ready = 1, `redirect_valid` with target 32'h200.
  - `kill_resp` = 1 that cycle.
  - `pc_actual` = 32'h200 on the next cycle.
- Deferred redirect: ready = 0, redirect to 32'h300, then a second redirect to 32'h400.
  - Stays in PEND at the old PC.
  - On ready: `kill_resp` = 1, `pc_next` = 32'h300, and 32'h400 is ignored.
- Misaligned redirect to 32'h202:
  - With the macro: `pc_next` = 32'h100 and `misalign_trap` = 1 for one cycle.
  - Without: `pc_next` = 32'h200.
- Reset asserted in PEND: `imem_req_valid` = 0 immediately, the pending target is dropped, and the boot sequence repeats. Wrap case: PC 32'hFFFF_FFFC with acc gives `pc_next` = 0.
